// File: rtl/ring_phase_checker.sv
// Receiver/supervisor for a 4-bit one-hot ring counter. It decodes the phase,
// locks after enough correct advances, and flags and counts faults while locked.
module ring_phase_checker #(
  parameter int unsigned LOCK_COUNT = 3,
  parameter bit          ALLOW_HOLD = 1'b0,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             ORI,
  input  logic [3:0]       ring_in,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned RING_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state;
  logic [RING_W-1:0]  prev;
  logic [CNT_W-1:0]   good_cnt;

  logic               in_onehot;
  logic               prev_onehot;
  logic [1:0]         in_index;
  logic [RING_W-1:0]  rotated;
  logic               step_legal;
  logic [CNT_W-1:0]   good_inc;
  logic               count_sat;

  function automatic logic is_onehot(input logic [RING_W-1:0] x);
    return (x == 4'b0001) || (x == 4'b0010) || (x == 4'b0100) || (x == 4'b1000);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [RING_W-1:0] x);
    logic [1:0] idx;
    idx = 2'd0;
    case (x)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // A step is legal only between two one-hot patterns in ring order (or a hold).
  always_comb begin
    in_onehot   = is_onehot(ring_in);
    prev_onehot = is_onehot(prev);
    in_index    = onehot_index(ring_in);
    rotated     = {prev[2:0], prev[3]};
    step_legal  = in_onehot && prev_onehot &&
                  ((ring_in == rotated) || (ALLOW_HOLD && (ring_in == prev)));
    good_inc    = good_cnt + CNT_W'(1);
    count_sat   = &err_count;
  end

  always_ff @(posedge clk) begin
    if (!ORI) begin
      state       <= ST_SEARCH;
      prev        <= '0;
      good_cnt    <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      prev        <= ring_in;
      phase_valid <= in_onehot;
      err_pulse   <= 1'b0;
      if (in_onehot) begin
        phase <= in_index;
      end

      case (state)
        ST_SEARCH: begin
          locked <= 1'b0;
          if (in_onehot) begin
            state    <= ST_TRACK;
            good_cnt <= '0;
          end
        end
        ST_TRACK: begin
          if (step_legal) begin
            if (good_inc == CNT_W'(LOCK_COUNT)) begin
              state    <= ST_LOCKED;
              good_cnt <= '0;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_inc;
              locked   <= 1'b0;
            end
          end else begin
            // Faults before lock only restart acquisition; nothing is reported.
            good_cnt <= '0;
            locked   <= 1'b0;
            state    <= in_onehot ? ST_TRACK : ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (step_legal) begin
            locked <= 1'b1;
          end else begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b1;
            if (!count_sat) begin
              err_count <= err_count + ERR_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase

      // Clear takes priority over a same-edge increment.
      if (clr_err) begin
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_checker.sv
// Scoreboard bench for ring_phase_checker: three instances (default, hold allowed,
// 2-bit error counter) share stimulus; each vector names the instance it checks.
module tb_ring_phase_checker;

  logic       clk;
  logic       ori;
  logic [3:0] ring_in;
  logic       clr_err;

  logic [1:0] phase0, phase1, phase2;
  logic       pv0, pv1, pv2;
  logic       lk0, lk1, lk2;
  logic       pu0, pu1, pu2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  ring_phase_checker #(.LOCK_COUNT(3), .ALLOW_HOLD(1'b0), .ERR_W(8)) dut0 (
    .clk(clk), .ORI(ori), .ring_in(ring_in), .clr_err(clr_err),
    .phase(phase0), .phase_valid(pv0), .locked(lk0), .err_pulse(pu0), .err_count(cnt0));

  ring_phase_checker #(.LOCK_COUNT(3), .ALLOW_HOLD(1'b1), .ERR_W(8)) dut1 (
    .clk(clk), .ORI(ori), .ring_in(ring_in), .clr_err(clr_err),
    .phase(phase1), .phase_valid(pv1), .locked(lk1), .err_pulse(pu1), .err_count(cnt1));

  ring_phase_checker #(.LOCK_COUNT(3), .ALLOW_HOLD(1'b0), .ERR_W(2)) dut2 (
    .clk(clk), .ORI(ori), .ring_in(ring_in), .clr_err(clr_err),
    .phase(phase2), .phase_valid(pv2), .locked(lk2), .err_pulse(pu2), .err_count(cnt2));

  typedef struct {
    int         sel;
    logic [1:0] phase;
    logic       pv;
    logic       lk;
    logic       pu;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per sampled edge, compared after outputs settle.
  always @(posedge clk) begin
    exp_t       e;
    logic [1:0] a_ph;
    logic       a_pv, a_lk, a_pu;
    logic [7:0] a_cnt;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        1:       begin a_ph = phase1; a_pv = pv1; a_lk = lk1; a_pu = pu1; a_cnt = cnt1; end
        2:       begin a_ph = phase2; a_pv = pv2; a_lk = lk2; a_pu = pu2; a_cnt = {6'b0, cnt2}; end
        default: begin a_ph = phase0; a_pv = pv0; a_lk = lk0; a_pu = pu0; a_cnt = cnt0; end
      endcase
      checks++;
      if ({a_ph, a_pv, a_lk, a_pu, a_cnt} === {e.phase, e.pv, e.lk, e.pu, e.cnt}) begin
        passed++;
      end else begin
        $display("FAIL %s (dut%0d): got phase=%0d pv=%b locked=%b pulse=%b cnt=%0d, want phase=%0d pv=%b locked=%b pulse=%b cnt=%0d",
                 e.name, e.sel, a_ph, a_pv, a_lk, a_pu, a_cnt,
                 e.phase, e.pv, e.lk, e.pu, e.cnt);
      end
    end
  end

  // Drive one edge worth of inputs and queue what must appear after that edge.
  task automatic step(input int sel, input logic o, input logic c, input logic [3:0] r,
                      input logic [1:0] ph, input logic pv, input logic lk,
                      input logic pu, input logic [7:0] cnt, input string name);
    exp_t e;
    @(negedge clk);
    ori     = o;
    clr_err = c;
    ring_in = r;
    e.sel = sel; e.phase = ph; e.pv = pv; e.lk = lk; e.pu = pu; e.cnt = cnt; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] sat_cnt [5];
    sat_cnt = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    ori = 1'b0; clr_err = 1'b0; ring_in = 4'b0000;

    // Reset (clr_err asserted too: reset must win) and clean rotation to lock.
    step(0, 0, 1, 4'b0001, 0, 0, 0, 0, 0, "reset_a");
    step(0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, "reset_b");
    step(0, 1, 0, 4'b0001, 0, 1, 0, 0, 0, "rot_p0");
    step(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, "rot_p1");
    step(0, 1, 0, 4'b0100, 2, 1, 0, 0, 0, "rot_p2");
    step(0, 1, 0, 4'b1000, 3, 1, 1, 0, 0, "rot_lock");
    step(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, "rot_wrap");
    step(0, 1, 0, 4'b0010, 1, 1, 1, 0, 0, "rot_p1b");
    // Two-hot pattern while locked.
    step(0, 1, 0, 4'b0011, 1, 0, 0, 1, 1, "twohot_fault");
    step(0, 1, 0, 4'b0100, 2, 1, 0, 0, 1, "relock1_s1");
    step(0, 1, 0, 4'b1000, 3, 1, 0, 0, 1, "relock1_s2");
    step(0, 1, 0, 4'b0001, 0, 1, 0, 0, 1, "relock1_s3");
    step(0, 1, 0, 4'b0010, 1, 1, 1, 0, 1, "relock1_s4");
    // Skipped phase.
    step(0, 1, 0, 4'b0100, 2, 1, 1, 0, 1, "pre_skip_a");
    step(0, 1, 0, 4'b1000, 3, 1, 1, 0, 1, "pre_skip_b");
    step(0, 1, 0, 4'b0001, 0, 1, 1, 0, 1, "pre_skip_c");
    step(0, 1, 0, 4'b0100, 2, 1, 0, 1, 2, "skip_fault");
    step(0, 1, 0, 4'b1000, 3, 1, 0, 0, 2, "relock2_s1");
    step(0, 1, 0, 4'b0001, 0, 1, 0, 0, 2, "relock2_s2");
    step(0, 1, 0, 4'b0010, 1, 1, 0, 0, 2, "relock2_s3");
    step(0, 1, 0, 4'b0100, 2, 1, 1, 0, 2, "relock2_s4");
    // Reverse rotation.
    step(0, 1, 0, 4'b0010, 1, 1, 0, 1, 3, "reverse_fault");
    step(0, 1, 0, 4'b0100, 2, 1, 0, 0, 3, "pulse_one_cycle");
    step(0, 1, 0, 4'b1000, 3, 1, 0, 0, 3, "relock3_s2");
    step(0, 1, 0, 4'b0001, 0, 1, 0, 0, 3, "relock3_s3");
    step(0, 1, 0, 4'b0010, 1, 1, 1, 0, 3, "relock3_s4");
    // Repeated pattern with holds disallowed.
    step(0, 1, 0, 4'b0100, 2, 1, 1, 0, 3, "nohold_a");
    step(0, 1, 0, 4'b1000, 3, 1, 1, 0, 3, "nohold_b");
    step(0, 1, 0, 4'b0001, 0, 1, 1, 0, 3, "nohold_c");
    step(0, 1, 0, 4'b0001, 0, 1, 0, 1, 4, "nohold_fault");
    step(0, 1, 0, 4'b0010, 1, 1, 0, 0, 4, "nohold_after");
    step(0, 1, 0, 4'b0100, 2, 1, 0, 0, 4, "relock4_s2");
    step(0, 1, 0, 4'b1000, 3, 1, 0, 0, 4, "relock4_s3");
    step(0, 1, 0, 4'b0001, 0, 1, 1, 0, 4, "relock4_s4");
    // Mid-lock reset discards everything.
    step(0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, "midreset");
    step(0, 1, 0, 4'b0010, 1, 1, 0, 0, 0, "postrst_s1");
    step(0, 1, 0, 4'b0100, 2, 1, 0, 0, 0, "postrst_s2");
    step(0, 1, 0, 4'b1000, 3, 1, 0, 0, 0, "postrst_s3");
    step(0, 1, 0, 4'b0001, 0, 1, 1, 0, 0, "postrst_lock");

    // Holds allowed: holds count toward lock and do not fault while locked.
    step(1, 0, 0, 4'b0001, 0, 0, 0, 0, 0, "hold_reset");
    step(1, 1, 0, 4'b0001, 0, 1, 0, 0, 0, "hold_s1");
    step(1, 1, 0, 4'b0001, 0, 1, 0, 0, 0, "hold_s2");
    step(1, 1, 0, 4'b0001, 0, 1, 0, 0, 0, "hold_s3");
    step(1, 1, 0, 4'b0001, 0, 1, 1, 0, 0, "hold_lock");
    step(1, 1, 0, 4'b0010, 1, 1, 1, 0, 0, "hold_adv_a");
    step(1, 1, 0, 4'b0100, 2, 1, 1, 0, 0, "hold_adv_b");
    step(1, 1, 0, 4'b1000, 3, 1, 1, 0, 0, "hold_adv_c");
    step(1, 1, 0, 4'b0001, 0, 1, 1, 0, 0, "hold_0001_a");
    step(1, 1, 0, 4'b0001, 0, 1, 1, 0, 0, "hold_0001_b");
    step(1, 1, 0, 4'b0010, 1, 1, 1, 0, 0, "hold_0010");
    step(1, 1, 0, 4'b0000, 1, 0, 0, 1, 1, "hold_zero_fault");

    // 2-bit counter: saturation, then clear racing a sixth fault.
    step(2, 0, 0, 4'b0000, 0, 0, 0, 0, 0, "sat_reset");
    for (int k = 0; k < 6; k++) begin
      logic [7:0] prior;
      logic [7:0] after;
      logic       clr_now;
      prior   = (k == 0) ? 8'd0 : sat_cnt[(k > 5) ? 4 : k - 1];
      clr_now = (k == 5);
      after   = clr_now ? 8'd0 : sat_cnt[(k > 4) ? 4 : k];
      step(2, 1, 0, 4'b0001, 0, 1, 0, 0, prior, $sformatf("sat%0d_s1", k));
      step(2, 1, 0, 4'b0010, 1, 1, 0, 0, prior, $sformatf("sat%0d_s2", k));
      step(2, 1, 0, 4'b0100, 2, 1, 0, 0, prior, $sformatf("sat%0d_s3", k));
      step(2, 1, 0, 4'b1000, 3, 1, 1, 0, prior, $sformatf("sat%0d_lock", k));
      step(2, 1, clr_now, 4'b0000, 3, 0, 0, 1, after, $sformatf("sat%0d_fault", k));
    end
    step(2, 1, 0, 4'b0001, 0, 1, 0, 0, 0, "sat_after_clear");

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
      @(posedge clk);
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
